// File: rtl/param_ram_clr_pkg.sv
// Shared definitions for the clearing RAM: FSM encoding and depth helper.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/param_ram_clr_array.sv
// Unreset word storage with one write port and one enabled synchronous read port.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Non-blocking read and write on one edge gives read-before-write.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/param_ram_clr.sv
// Single-port RAM with a clear sweep after reset or on CLR, and a 1- or 2-cycle read path.
module param_ram_clr
    import ram_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 14,
    parameter int                READ_LAT  = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              E,
    input  logic              W,
    input  logic              R,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] OUT,
    output logic              VALID,
    output logic              BUSY
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(depth(ADDR_W) - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              clr_we;
    logic              req_ok, usr_we, rd_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // The pointer parks at the last word; only a new sweep moves it back to 0.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (CLR)                  ptr_nxt   = '0;
                else if (ptr == PTR_LAST) state_nxt = ST_READY;
                else                      ptr_nxt   = ptr + 1'b1;
            end
            ST_READY: begin
                if (CLR) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
        endcase
    end

    assign BUSY      = (state == ST_CLEAR);
    assign req_ok    = E & ~BUSY & ~CLR;
    assign usr_we    = req_ok & W;
    assign rd_acc    = req_ok & R;
    assign mem_we    = clr_we | usr_we;
    assign mem_waddr = clr_we ? ptr : ADDR;
    assign mem_wdata = clr_we ? CLEAR_VAL : D;

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_acc),
        .raddr (ADDR),
        .rdata (rdata)
    );

    generate
        if (READ_LAT == 1) begin : g_lat1
            // rdata only loads on accepted reads, so it already holds; out_live masks it to 0 until the first read.
            logic out_live;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    out_live <= 1'b0;
                    VALID    <= 1'b0;
                end else begin
                    VALID <= rd_acc;
                    if (rd_acc) out_live <= 1'b1;
                end
            end
            assign OUT = out_live ? rdata : '0;
        end else if (READ_LAT == 2) begin : g_lat2
            logic [1:0] vld_pipe;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    vld_pipe <= '0;
                    OUT      <= '0;
                end else begin
                    vld_pipe <= {vld_pipe[0], rd_acc};
                    if (vld_pipe[0]) OUT <= rdata;
                end
            end
            assign VALID = vld_pipe[1];
        end else begin : g_bad_lat
            $error("param_ram_clr: READ_LAT must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_param_ram_clr.sv
// Bench for param_ram_clr: READ_LAT=1 and READ_LAT=2 instances share stimulus and a behavioural model.
module tb_param_ram_clr;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          e = 1'b0, w = 1'b0, r = 1'b0, clr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] d = '0;
    logic [DW-1:0] out1, out2;
    logic          valid1, valid2, busy1, busy2;

    always #5 clk = ~clk;

    param_ram_clr #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .CLEAR_VAL(16'h0000)) dut1 (
        .CLK(clk), .RST(rst), .E(e), .W(w), .R(r), .CLR(clr),
        .ADDR(addr), .D(d), .OUT(out1), .VALID(valid1), .BUSY(busy1)
    );

    param_ram_clr #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2), .CLEAR_VAL(16'h0000)) dut2 (
        .CLK(clk), .RST(rst), .E(e), .W(w), .R(r), .CLR(clr),
        .ADDR(addr), .D(d), .OUT(out2), .VALID(valid2), .BUSY(busy2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: memory contents, cycles of sweep remaining, reads queued with the cycle they retire on.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    logic [DW-1:0] mem [N];
    int            busy_left;
    int            cyc = 0;
    rd_t           q1[$];
    rd_t           q2[$];
    logic [DW-1:0] eo1, eo2;
    logic          ev1, ev2;

    typedef struct {
        logic          w;
        logic          r;
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
        logic          ev;
        logic [DW-1:0] eo;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mem[i]) mem[i] = '0;
        busy_left = N;
        q1.delete();
        q2.delete();
        eo1 = '0; eo2 = '0;
        ev1 = 1'b0; ev2 = 1'b0;
    endtask

    task automatic model_edge();
        rd_t t;
        cyc++;
        if (busy_left > 0) begin
            busy_left = clr ? N : busy_left - 1;
        end else if (clr) begin
            busy_left = N;
            foreach (mem[i]) mem[i] = '0;
        end else if (e) begin
            if (r) begin
                t.data = mem[addr];
                t.due  = cyc;
                q1.push_back(t);
                t.due  = cyc + 1;
                q2.push_back(t);
            end
            if (w) mem[addr] = d;
        end
    endtask

    task automatic model_outputs();
        ev1 = 1'b0;
        ev2 = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            eo1 = q1[0].data; ev1 = 1'b1; void'(q1.pop_front());
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            eo2 = q2[0].data; ev2 = 1'b1; void'(q2.pop_front());
        end
    endtask

    task automatic compare_all();
        check("busy1",  32'(busy1),  32'(busy_left > 0));
        check("busy2",  32'(busy2),  32'(busy_left > 0));
        check("valid1", 32'(valid1), 32'(ev1));
        check("valid2", 32'(valid2), 32'(ev2));
        check("out1",   32'(out1),   32'(eo1));
        check("out2",   32'(out2),   32'(eo2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_outputs();
        compare_all();
    endtask

    task automatic set_in(input logic ie, input logic iw, input logic ir, input logic iclr,
                          input logic [AW-1:0] ia, input logic [DW-1:0] id);
        e = ie; w = iw; r = ir; clr = iclr; addr = ia; d = id;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Counts cycles until BUSY drops, bounded so a stuck sweep still reaches the summary.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy1 && cnt < 100) begin
            tick();
            idle();
            cnt++;
        end
    endtask

    initial begin
        int cnt;
        logic [DW-1:0] v;

        tbl[0] = '{1'b1, 1'b0, 4'd3,  16'h1234, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 4'd15, 16'hBEEF, 1'b0, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 4'd3,  16'h0000, 1'b1, 16'h1234};
        tbl[3] = '{1'b0, 1'b1, 4'd15, 16'h0000, 1'b1, 16'hBEEF};
        tbl[4] = '{1'b1, 1'b0, 4'd5,  16'h00AA, 1'b0, 16'hBEEF};
        tbl[5] = '{1'b1, 1'b1, 4'd5,  16'h0055, 1'b1, 16'h00AA};
        tbl[6] = '{1'b0, 1'b1, 4'd5,  16'h0000, 1'b1, 16'h0055};
        tbl[7] = '{1'b0, 1'b0, 4'd5,  16'h0000, 1'b0, 16'h0055};

        // Reset state
        model_reset();
        idle();
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Power-up sweep lasts DEPTH cycles, then every word reads back as the clear value
        count_busy(cnt);
        check("sweep_len_reset", 32'(cnt), 32'd16);
        for (int i = 0; i < N; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 1'b0, AW'(i), '0);
            tick();
            check("init_rd_valid", 32'(valid1), 32'd1);
            check("init_rd_data",  32'(out1),   32'h0);
        end
        idle();
        tick();

        // Write/read vectors, including same-cycle read-before-write
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, tbl[i].w, tbl[i].r, 1'b0, tbl[i].addr, tbl[i].d);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(valid1), 32'(tbl[i].ev));
            check($sformatf("vec%0d_out", i),   32'(out1),   32'(tbl[i].eo));
        end

        // Fill with nonzero data, CLR, write during the sweep is dropped
        for (int i = 0; i < N; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, AW'(i), DW'($urandom_range(1, 16'hFFFF)));
            tick();
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 16'h7777);
        tick();
        check("clr_read_dropped", 32'(valid1), 32'd0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 16'hDEAD);
        count_busy(cnt);
        check("sweep_len_clr", 32'(cnt), 32'd16);
        for (int i = 0; i < N; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 1'b0, AW'(i), '0);
            tick();
            check("post_clr_data", 32'(out1), 32'h0);
        end

        // Reset with ptr at 7 mid-sweep
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 16'h5A5A);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, '0);
        tick();
        idle();
        tick();
        check("pre_rst_out2", 32'(out2), 32'h5A5A);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        tick();
        idle();
        for (int i = 0; i < 7; i++) tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_out1",   32'(out1),   32'h0);
        check("rst_async_out2",   32'(out2),   32'h0);
        check("rst_async_valid1", 32'(valid1), 32'h0);
        check("rst_async_busy",   32'(busy1),  32'h1);
        @(negedge clk);
        rst = 1'b0;
        count_busy(cnt);
        check("sweep_len_rst", 32'(cnt), 32'd16);

        // READ_LAT=2 back-to-back reads and E=0 reads
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, AW'(i), DW'(16'h0100 * i + i));
            tick();
        end
        for (int i = 1; i <= 5; i++) begin
            if (i <= 3) set_in(1'b1, 1'b0, 1'b1, 1'b0, AW'(i), '0);
            else idle();
            tick();
            check($sformatf("lat2_valid_%0d", i), 32'(valid2), (i >= 2 && i <= 4) ? 32'd1 : 32'd0);
            if (i >= 2 && i <= 4) begin
                v = DW'(16'h0100 * (i - 1) + (i - 1));
                check($sformatf("lat2_out_%0d", i), 32'(out2), 32'(v));
            end
        end
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, '0);
        tick();
        tick();
        check("e0_no_valid2", 32'(valid2), 32'd0);
        check("e0_no_valid1", 32'(valid1), 32'd0);

        // Randomized traffic with occasional CLR
        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                   $urandom_range(0, 39) == 0, AW'($urandom), DW'($urandom));
            tick();
        end
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
